// File: rtl/prog_loader_ctrl.sv
// Program loader: parses a header/payload word stream into instruction and data
// memory writes, then releases the processor for a bounded number of cycles.
module prog_loader_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       run_cycles,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              instr_write_enable,
  output logic [7:0]        instr_write_addr,
  output logic [DATA_W-1:0] instr_write_data,
  output logic              data_init_write_enable,
  output logic [7:0]        data_init_addr,
  output logic [DATA_W-1:0] data_init_data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, DRAIN, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [15:0]       budget, run_cnt;
  logic              seg_tgt, seg_last;
  logic [7:0]        seg_base, seg_cnt_m1, seg_idx;
  logic              done_r, err_r;
  logic              hs, active, accept_start, take_abort, last_word, run_end;
  logic              instr_vld_p1, data_vld_p1;
  logic [7:0]        instr_addr_p1, data_addr_p1;
  logic [DATA_W-1:0] instr_data_p1, data_data_p1;
  logic              unused_hdr_bits;

  assign unused_hdr_bits = ^in_data[29:16];

  assign in_ready     = (state == HDR) || (state == PAYLOAD);
  assign active       = (state == HDR) || (state == PAYLOAD) || (state == DRAIN) || (state == RUN);
  assign hs           = in_valid & in_ready;
  assign take_abort   = abort & active;
  assign accept_start = start & ((state == IDLE) || (state == DONE));
  assign last_word    = (seg_idx == seg_cnt_m1);
  // run_cnt is 0 in the first RUN cycle, so leaving at budget-1 gives exactly budget RUN cycles
  assign run_end      = (budget != 16'd0) && (run_cnt == budget - 16'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = HDR;
      HDR:        if (abort) state_nxt = IDLE;
                  else if (hs) state_nxt = PAYLOAD;
      PAYLOAD:    if (abort) state_nxt = IDLE;
                  else if (hs && last_word) state_nxt = seg_last ? DRAIN : HDR;
      DRAIN:      state_nxt = abort ? IDLE : RUN;
      RUN:        if (abort) state_nxt = IDLE;
                  else if (run_end) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      budget        <= '0;
      run_cnt       <= '0;
      seg_tgt       <= 1'b0;
      seg_last      <= 1'b0;
      seg_base      <= '0;
      seg_cnt_m1    <= '0;
      seg_idx       <= '0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      instr_vld_p1  <= 1'b0;
      instr_addr_p1 <= '0;
      instr_data_p1 <= '0;
      data_vld_p1   <= 1'b0;
      data_addr_p1  <= '0;
      data_data_p1  <= '0;
    end else begin
      state        <= state_nxt;
      instr_vld_p1 <= 1'b0;
      data_vld_p1  <= 1'b0;
      if (accept_start) begin
        budget <= run_cycles;
        done_r <= 1'b0;
        err_r  <= 1'b0;
      end
      if (take_abort) err_r <= 1'b1;
      if ((state == RUN) && run_end && !abort) done_r <= 1'b1;
      if (state == DRAIN) run_cnt <= '0;
      else if (state == RUN) run_cnt <= run_cnt + 16'd1;
      if ((state == HDR) && hs && !abort) begin
        seg_tgt    <= in_data[31];
        seg_last   <= in_data[30];
        seg_base   <= in_data[15:8];
        seg_cnt_m1 <= in_data[7:0];
        seg_idx    <= '0;
      end
      // write stage p1: accepted payload word becomes a one-cycle strobe on its target
      if ((state == PAYLOAD) && hs && !abort) begin
        seg_idx <= seg_idx + 8'd1;
        if (seg_tgt) begin
          data_vld_p1  <= 1'b1;
          data_addr_p1 <= seg_base + seg_idx;
          data_data_p1 <= in_data;
        end else begin
          instr_vld_p1  <= 1'b1;
          instr_addr_p1 <= seg_base + seg_idx;
          instr_data_p1 <= in_data;
        end
      end
    end
  end

  assign instr_write_enable     = instr_vld_p1;
  assign instr_write_addr       = instr_addr_p1;
  assign instr_write_data       = instr_data_p1;
  assign data_init_write_enable = data_vld_p1;
  assign data_init_addr         = data_addr_p1;
  assign data_init_data         = data_data_p1;
  assign cpu_reset              = (state != RUN);
  assign busy                   = active;
  assign done                   = done_r;
  assign err                    = err_r;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Directed bench for prog_loader_ctrl: load, multi-segment, backpressure/wrap,
// abort and reset-during-run scenarios with hand-computed expectations.
module tb_prog_loader_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, abort, in_valid;
  logic [15:0] run_cycles;
  logic [31:0] in_data;
  logic        in_ready, instr_write_enable, data_init_write_enable;
  logic [7:0]  instr_write_addr, data_init_addr;
  logic [31:0] instr_write_data, data_init_data;
  logic        cpu_reset, busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  prog_loader_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .run_cycles(run_cycles),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .instr_write_enable(instr_write_enable), .instr_write_addr(instr_write_addr),
    .instr_write_data(instr_write_data), .data_init_write_enable(data_init_write_enable),
    .data_init_addr(data_init_addr), .data_init_data(data_init_data),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick();
    tick();
    n_cmp++; if (cpu_reset !== 1'b1) begin n_bad++; $display("FAIL rst_cpu_reset got %b exp 1", cpu_reset); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    n_cmp++; if ({busy, done, err} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got %b exp 000", {busy, done, err}); end
    n_cmp++; if ({instr_write_enable, data_init_write_enable} !== 2'b00) begin n_bad++; $display("FAIL rst_strobes got %b exp 00", {instr_write_enable, data_init_write_enable}); end
    n_cmp++; if ({instr_write_addr, data_init_addr} !== 16'h0) begin n_bad++; $display("FAIL rst_addrs got %h exp 0", {instr_write_addr, data_init_addr}); end
    n_cmp++; if ({instr_write_data, data_init_data} !== 64'h0) begin n_bad++; $display("FAIL rst_data got %h exp 0", {instr_write_data, data_init_data}); end
    reset = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_idle_hold got busy=%b exp 0", busy); end
  endtask

  task automatic test_load;
    logic [31:0] w [3];
    int low;
    w[0] = 32'hAAAA_0001; w[1] = 32'hBBBB_0002; w[2] = 32'hCCCC_0003;
    run_cycles = 16'd10; start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if ({busy, in_ready, done} !== 3'b110) begin n_bad++; $display("FAIL load_hdr_state got %b exp 110", {busy, in_ready, done}); end
    in_valid = 1'b1; in_data = 32'h4000_0002;
    tick();
    n_cmp++; if (instr_write_enable !== 1'b0) begin n_bad++; $display("FAIL load_hdr_nostrobe got %b exp 0", instr_write_enable); end
    for (int i = 0; i < 3; i++) begin
      in_data = w[i];
      tick();
      n_cmp++; if ({instr_write_enable, data_init_write_enable} !== 2'b10) begin n_bad++; $display("FAIL load_strobe%0d got %b exp 10", i, {instr_write_enable, data_init_write_enable}); end
      n_cmp++; if (instr_write_addr !== 8'(i)) begin n_bad++; $display("FAIL load_addr%0d got %h exp %h", i, instr_write_addr, 8'(i)); end
      n_cmp++; if (instr_write_data !== w[i]) begin n_bad++; $display("FAIL load_data%0d got %h exp %h", i, instr_write_data, w[i]); end
    end
    in_valid = 1'b0; in_data = 32'h0;
    n_cmp++; if ({in_ready, cpu_reset} !== 2'b01) begin n_bad++; $display("FAIL load_drain got rdy/cpu_reset %b exp 01", {in_ready, cpu_reset}); end
    tick();
    n_cmp++; if ({instr_write_enable, instr_write_addr} !== 9'h002) begin n_bad++; $display("FAIL load_strobe_hold got %h exp 002", {instr_write_enable, instr_write_addr}); end
    low = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      if (!cpu_reset) low++;
      tick();
    end
    n_cmp++; if (low !== 10) begin n_bad++; $display("FAIL load_run_len got %0d exp 10", low); end
    n_cmp++; if ({done, cpu_reset, busy} !== 3'b110) begin n_bad++; $display("FAIL load_done got %b exp 110", {done, cpu_reset, busy}); end
  endtask

  task automatic test_multi_segment;
    int low, entries;
    logic prev;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if ({done, err} !== 2'b10) begin n_bad++; $display("FAIL multi_abort_in_done got %b exp 10", {done, err}); end
    run_cycles = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if ({done, busy} !== 2'b01) begin n_bad++; $display("FAIL multi_start got done/busy %b exp 01", {done, busy}); end
    in_valid = 1'b1; in_data = 32'h0000_1001;
    tick();
    in_data = 32'h1111_0000;
    tick();
    n_cmp++; if ({instr_write_enable, instr_write_addr, instr_write_data} !== {1'b1, 8'h10, 32'h1111_0000}) begin n_bad++; $display("FAIL multi_w0 got %b %h %h exp 1 10 11110000", instr_write_enable, instr_write_addr, instr_write_data); end
    in_data = 32'h1111_0001;
    tick();
    n_cmp++; if ({instr_write_enable, instr_write_addr, instr_write_data} !== {1'b1, 8'h11, 32'h1111_0001}) begin n_bad++; $display("FAIL multi_w1 got %b %h %h exp 1 11 11110001", instr_write_enable, instr_write_addr, instr_write_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL multi_hdr2_ready got %b exp 1", in_ready); end
    in_data = 32'hC000_2000;
    tick();
    n_cmp++; if ({instr_write_enable, data_init_write_enable} !== 2'b00) begin n_bad++; $display("FAIL multi_hdr2_nostrobe got %b exp 00", {instr_write_enable, data_init_write_enable}); end
    in_data = 32'hD000_00DD;
    tick();
    in_valid = 1'b0;
    n_cmp++; if ({data_init_write_enable, instr_write_enable, data_init_addr, data_init_data} !== {2'b10, 8'h20, 32'hD000_00DD}) begin n_bad++; $display("FAIL multi_data_w got %b %b %h %h exp 1 0 20 d00000dd", data_init_write_enable, instr_write_enable, data_init_addr, data_init_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL multi_drain_ready got %b exp 0", in_ready); end
    low = 0; entries = 0; prev = cpu_reset;
    for (int c = 0; c < 50 && !done; c++) begin
      tick();
      if (prev && !cpu_reset) entries++;
      if (!cpu_reset) low++;
      prev = cpu_reset;
    end
    n_cmp++; if (entries !== 1) begin n_bad++; $display("FAIL multi_run_entries got %0d exp 1", entries); end
    n_cmp++; if (low !== 3) begin n_bad++; $display("FAIL multi_run_len got %0d exp 3", low); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL multi_done got %b exp 1", done); end
  endtask

  task automatic test_backpressure_wrap;
    logic [7:0]  exp_addr [4];
    logic [31:0] bp [4];
    int k, nw;
    logic acc;
    exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00; exp_addr[3] = 8'h01;
    for (int i = 0; i < 4; i++) bp[i] = 32'hB000_0000 + 32'(i);
    run_cycles = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'h4000_FE03;
    tick();
    k = 0; nw = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      in_valid = (c % 2 == 1) && (k < 4);
      in_data = in_valid ? bp[k] : (32'hDEAD_BEEF ^ 32'(c));
      acc = in_valid && in_ready;
      tick();
      if (acc) k++;
      if (instr_write_enable) begin
        n_cmp++;
        if (nw >= 4) begin n_bad++; $display("FAIL bp_extra_write got addr %h exp none", instr_write_addr); end
        else if (instr_write_addr !== exp_addr[nw] || instr_write_data !== bp[nw]) begin
          n_bad++; $display("FAIL bp_write%0d got %h/%h exp %h/%h", nw, instr_write_addr, instr_write_data, exp_addr[nw], bp[nw]);
        end
        nw++;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (nw !== 4) begin n_bad++; $display("FAIL bp_write_count got %0d exp 4", nw); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL bp_done got %b exp 1", done); end
  endtask

  task automatic test_abort;
    run_cycles = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'h4000_0003;
    tick();
    in_data = 32'h5555_0001;
    tick();
    n_cmp++; if ({instr_write_enable, instr_write_addr, instr_write_data} !== {1'b1, 8'h00, 32'h5555_0001}) begin n_bad++; $display("FAIL abort_w0 got %b %h %h exp 1 00 55550001", instr_write_enable, instr_write_addr, instr_write_data); end
    in_data = 32'h5555_0002; abort = 1'b1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    n_cmp++; if (instr_write_enable !== 1'b0) begin n_bad++; $display("FAIL abort_nostrobe got %b exp 0", instr_write_enable); end
    n_cmp++; if ({busy, err, cpu_reset, in_ready} !== 4'b0110) begin n_bad++; $display("FAIL abort_idle got busy/err/cpu_reset/rdy %b exp 0110", {busy, err, cpu_reset, in_ready}); end
    tick();
    n_cmp++; if ({instr_write_enable, instr_write_data} !== {1'b0, 32'h5555_0001}) begin n_bad++; $display("FAIL abort_late got %b %h exp 0 55550001", instr_write_enable, instr_write_data); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if ({err, busy} !== 2'b10) begin n_bad++; $display("FAIL abort_in_idle got err/busy %b exp 10", {err, busy}); end
    run_cycles = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if ({err, busy} !== 2'b01) begin n_bad++; $display("FAIL abort_restart got err/busy %b exp 01", {err, busy}); end
  endtask

  task automatic test_reset_mid_run;
    int low;
    in_valid = 1'b1; in_data = 32'hC000_0500;
    tick();
    in_data = 32'hE1E1_E1E1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if ({data_init_write_enable, data_init_addr, data_init_data} !== {1'b1, 8'h05, 32'hE1E1_E1E1}) begin n_bad++; $display("FAIL rr_data_w got %b %h %h exp 1 05 e1e1e1e1", data_init_write_enable, data_init_addr, data_init_data); end
    tick();
    low = 0;
    for (int c = 0; c < 30; c++) begin
      if (!cpu_reset) low++;
      tick();
    end
    n_cmp++; if ({low, done} !== {32'd30, 1'b0}) begin n_bad++; $display("FAIL rr_unlimited got low=%0d done=%b exp 30 0", low, done); end
    run_cycles = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    n_cmp++; if ({cpu_reset, busy} !== 2'b01) begin n_bad++; $display("FAIL rr_start_ignored got cpu_reset/busy %b exp 01", {cpu_reset, busy}); end
    in_valid = 1'b1; in_data = 32'h4000_0000; reset = 1'b0; start = 1'b1; abort = 1'b1;
    tick();
    reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    n_cmp++; if ({cpu_reset, busy, done, err, in_ready} !== 5'b10000) begin n_bad++; $display("FAIL rr_ctrl got %b exp 10000", {cpu_reset, busy, done, err, in_ready}); end
    n_cmp++; if ({instr_write_enable, data_init_write_enable, instr_write_addr, data_init_addr} !== 18'h0) begin n_bad++; $display("FAIL rr_strobe_addr got %h exp 0", {instr_write_enable, data_init_write_enable, instr_write_addr, data_init_addr}); end
    n_cmp++; if ({instr_write_data, data_init_data} !== 64'h0) begin n_bad++; $display("FAIL rr_data got %h exp 0", {instr_write_data, data_init_data}); end
    tick();
    n_cmp++; if ({busy, cpu_reset} !== 2'b01) begin n_bad++; $display("FAIL rr_idle_after got busy/cpu_reset %b exp 01", {busy, cpu_reset}); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    in_data = 32'h0; run_cycles = 16'h0;
    test_reset();
    test_load();
    test_multi_segment();
    test_backpressure_wrap();
    test_abort();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_loader_ctrl.md
PROG_LOADER_CTRL -- requirements
Module: prog_loader_ctrl

Interface
REQ-001 SHALL have clock and reset ports: reset is synchronous and active-low; the clock is clk.
REQ-002 SHALL provide ports:
  clk  in  1  system clock, all state on rising edge
  reset  in  1  synchronous active-low reset
  start  in  1  one-cycle pulse, begin load session
  abort  in  1  one-cycle pulse, terminate session
  run_cycles  in  16  processor run budget, captured on accepted start; 0 = unlimited
  in_valid  in  1  load stream word valid
  in_ready  out  1  load stream word accepted when in_valid&in_ready
  in_data  in  32  load stream word (header or payload)
  instr_write_enable  out  1  instruction memory write strobe
  instr_write_addr  out  8  instruction memory word address
  instr_write_data  out  32  instruction memory write data
  data_init_write_enable  out  1  data memory init write strobe
  data_init_addr  out  8  data memory init word address
  data_init_data  out  32  data memory init write data
  cpu_reset  out  1  processor reset, active-high; 1 = processor held
  busy  out  1  session in progress (any state except IDLE/DONE)
  done  out  1  sticky, run budget expired
  err  out  1  sticky, session aborted

Function
REQ-003 SHALL implement states IDLE, HDR, PAYLOAD, DRAIN, RUN, DONE.
REQ-004 IDLE: cpu_reset=1, in_ready=0; start -> HDR, capture run_cycles, clear done and err.
REQ-005 start SHALL be ignored in HDR, PAYLOAD, DRAIN and RUN.
REQ-006 HDR: in_ready=1; accepted word decoded as header: bit31 target (0 instr, 1 data), bit30 last segment, bits[15:8] base address, bits[7:0] word count minus 1 (1..256 words); -> PAYLOAD.
REQ-007 PAYLOAD: in_ready=1; each accepted word SHALL produce exactly one write strobe on the selected target in the following cycle, address = base + index mod 256, data = accepted word.
REQ-008 Write strobes SHALL be single-cycle, registered; the non-selected target's strobe SHALL stay 0; address/data outputs hold their last values when strobe is 0.
REQ-009 After the final payload word of a segment: bit30=0 -> HDR; bit30=1 -> DRAIN.
REQ-010 in_valid low SHALL stall without losing state; in_data is ignored when no handshake occurs.
REQ-011 DRAIN: one cycle, in_ready=0, carries the final write strobe; -> RUN.
REQ-012 RUN: cpu_reset=0, in_ready=0; a 16-bit counter counts RUN cycles; when count reaches the captured budget (budget != 0) -> DONE, so cpu_reset is 0 for exactly run_cycles cycles.
REQ-013 Budget 0: RUN persists until abort or reset.
REQ-014 DONE: cpu_reset=1, done=1; start -> HDR (new session).
REQ-015 abort in HDR, PAYLOAD, DRAIN or RUN SHALL go to IDLE next cycle with cpu_reset=1, err=1; abort in IDLE or DONE SHALL be ignored.
REQ-016 abort coincident with a handshake SHALL win: the word is not written and no strobe follows.
REQ-017 Address wrap: base 0xFE with count 4 SHALL write addresses FE, FF, 00, 01.
REQ-018 Instruction and data segments MAY appear in any order and number within a session.

Reset
REQ-019 reset=0 at a rising edge SHALL force IDLE; cpu_reset=1, in_ready=0, both strobes=0, all addresses and data=0, busy=0, done=0, err=0, counters=0.
REQ-020 reset SHALL take priority over start, abort and handshakes, including mid-segment and mid-RUN; a partial segment is discarded.

Verification
REQ-021 Load: start with run_cycles=10; header 0x4000_0002 plus words A,B,C -> instr strobes at addresses 00,01,02 with A,B,C; cpu_reset low for exactly 10 cycles; then done=1.
REQ-022 Multi-segment: header 0x0000_1001 plus 2 words, then header 0xC000_2000 plus 1 word -> instr writes at 10,11; data write at 20; RUN entered once.
REQ-023 Backpressure/wrap: header 0x4000_FE03 with in_valid toggled every cycle -> writes at FE,FF,00,01 in order, no duplicates or drops.
REQ-024 Abort: abort coincident with the 2nd payload handshake -> only 1 strobe occurs; IDLE, err=1, cpu_reset=1; a subsequent start clears err.
REQ-025 Reset mid-RUN with budget 0 -> next cycle cpu_reset=1, all outputs at reset values; start during RUN has no effect.
